// File: rtl/sm_para_ctrl_pkg.sv
// Shared types and helpers for the sm_para_ctrl protocol checker.
// Holds state codes, the per-state output decode and the counter-width helper.
package sm_para_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_S1   = 2'b01,
      ST_S2   = 2'b10,
      ST_ERR  = 2'b11
   } state_t;

   typedef struct packed {
      logic o1;
      logic o2;
      logic err;
   } outs_t;

   function automatic outs_t decode_outs(state_t s);
      outs_t r;
      r = '0;
      unique case (s)
         ST_S1:   r.o1  = 1'b1;
         ST_S2:   r.o2  = 1'b1;
         ST_ERR:  r.err = 1'b1;
         default: r     = '0;
      endcase
      return r;
   endfunction

   function automatic int imax(int a, int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_width(int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sm_dwell_cnt.sv
// Saturating cycle counter with synchronous clear and increment enable.
// Ports: clk, nrst (async active-low), clr, inc, cnt (holds at MAX).
module sm_dwell_cnt #(
   parameter int MAX = 16,
   parameter int W   = 5
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX_V)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/sm_para_ctrl.sv
// Two-input IDLE/S1/S2/ERROR protocol controller with dwell timeout,
// error hold/sticky error, sync clear and saturating error-entry counter.
// Ports: clk, nrst, i1, i2, clr in; o1, o2, err, state, err_cnt out.
module sm_para_ctrl
   import sm_para_ctrl_pkg::*;
#(
   parameter int TIMEOUT  = 16,
   parameter int ERR_HOLD = 0,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             i1,
   input  logic             i2,
   input  logic             clr,
   output logic             o1,
   output logic             o2,
   output logic             err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int DMAX = imax(TIMEOUT, ERR_HOLD);
   localparam int DW   = cnt_width(DMAX);

   localparam logic [DW-1:0] TO_LAST =
      DW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [DW-1:0] HOLD_LAST =
      DW'((ERR_HOLD > 0) ? ERR_HOLD - 1 : 0);

   state_t        cur;
   state_t        nxt;
   state_t        dec;
   logic [DW-1:0] dwell;
   logic          dwell_clr;
   outs_t         nouts;

   // Dwell counts edges spent in the current state; restarts on any change.
   assign dwell_clr = clr | (nxt != cur);

   sm_dwell_cnt #(
      .MAX (DMAX),
      .W   (DW)
   ) u_dwell (
      .clk  (clk),
      .nrst (nrst),
      .clr  (dwell_clr),
      .inc  (1'b1),
      .cnt  (dwell)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cur <= ST_IDLE;
      end else begin
         cur <= nxt;
      end
   end

   always_comb begin
      dec = cur;
      unique case (cur)
         ST_IDLE: begin
            unique case ({i1, i2})
               2'b10:   dec = ST_S1;
               2'b11:   dec = ST_ERR;
               default: dec = ST_IDLE;
            endcase
         end
         ST_S1: begin
            unique case ({i1, i2})
               2'b11:   dec = ST_S2;
               2'b01:   dec = ST_ERR;
               default: dec = ST_S1;
            endcase
         end
         ST_S2: begin
            unique case ({i1, i2})
               2'b00:   dec = ST_IDLE;
               2'b10:   dec = ST_ERR;
               default: dec = ST_S2;
            endcase
         end
         default: dec = ST_ERR;
      endcase

      nxt = dec;
      // Timeout only fires when the decode would have stayed put,
      // so a legal move on the expiry edge still wins.
      if ((TIMEOUT != 0) && ((cur == ST_S1) || (cur == ST_S2))
          && (dwell == TO_LAST) && (dec == cur)) begin
         nxt = ST_ERR;
      end
      if ((ERR_HOLD != 0) && (cur == ST_ERR)
          && (dwell == HOLD_LAST)) begin
         nxt = ST_IDLE;
      end
      if (clr) begin
         nxt = ST_IDLE;
      end
   end

   assign nouts = decode_outs(nxt);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         o1      <= 1'b0;
         o2      <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         o1  <= nouts.o1;
         o2  <= nouts.o2;
         err <= nouts.err;
         if (clr) begin
            err_cnt <= '0;
         end else if ((nxt == ST_ERR) && (cur != ST_ERR)
                      && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
      end
   end

   assign state = cur;

endmodule
